// File: rtl/dac_channel_scheduler_pkg.sv
// +----------------------------------------------------------------------+
// | dac_sched_pkg: shared types, field widths and word packing for the    |
// | DAC channel scheduler.                          Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

package dac_sched_pkg;

  localparam int NREQ   = 4;
  localparam int PTR_W  = $clog2(NREQ);
  localparam int CMD_W  = 4;
  localparam int CHAN_W = 4;
  localparam int CODE_W = 16;
  localparam int PAD_W  = 8;
  localparam int WORD_W = CMD_W + CHAN_W + CODE_W + PAD_W;

  localparam logic [CMD_W-1:0] CMD_WR_UPD_DEF = 4'h3;
  localparam logic [CMD_W-1:0] CMD_BCAST      = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [CMD_W-1:0]  cmd,
    input logic [CHAN_W-1:0] chan,
    input logic [CODE_W-1:0] code
  );
    return {cmd, chan, code, {PAD_W{1'b0}}};
  endfunction

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dac_channel_scheduler_if.sv
// +----------------------------------------------------------------------+
// | dac_sched_if: requester and SPI-driver side signals of the scheduler; |
// | broadcast signals exist only with DAC_SCHED_BROADCAST_EN. Rev: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

interface dac_sched_if import dac_sched_pkg::*; ();

  logic [NREQ-1:0]        i_req;
  logic [NREQ*CHAN_W-1:0] i_chan;
  logic [NREQ*CODE_W-1:0] i_code;
  logic [NREQ-1:0]        o_grant;
  logic [WORD_W-1:0]      o_DAC_DATA;
  logic                   o_DataValid;
  logic                   i_drv_ready;
  logic                   o_busy;
`ifdef DAC_SCHED_BROADCAST_EN
  logic                   i_bcast_req;
  logic [CODE_W-1:0]      i_bcast_code;
  logic                   o_bcast_ack;
`endif

  modport master (
    output i_req, i_chan, i_code, i_drv_ready,
`ifdef DAC_SCHED_BROADCAST_EN
    output i_bcast_req, i_bcast_code,
    input  o_bcast_ack,
`endif
    input  o_grant, o_DAC_DATA, o_DataValid, o_busy
  );

  modport slave (
    input  i_req, i_chan, i_code, i_drv_ready,
`ifdef DAC_SCHED_BROADCAST_EN
    input  i_bcast_req, i_bcast_code,
    output o_bcast_ack,
`endif
    output o_grant, o_DAC_DATA, o_DataValid, o_busy
  );

endinterface

`default_nettype wire

// File: rtl/dac_channel_scheduler_arbiter.sv
// +----------------------------------------------------------------------+
// | dac_rr_arbiter: combinational round-robin pick starting at pointer.   |
// |                                                 Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module dac_rr_arbiter import dac_sched_pkg::*; (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] pointer,
  output logic [NREQ-1:0]  grant,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  // NREQ is a power of two, so pointer+i wraps naturally in PTR_W bits
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = pointer + PTR_W'(i);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dac_channel_scheduler.sv
// +----------------------------------------------------------------------+
// | dac_channel_scheduler: round-robin DAC word scheduler feeding an SPI  |
// | byte driver; optional broadcast via DAC_SCHED_BROADCAST_EN. Rev: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module dac_channel_scheduler import dac_sched_pkg::*; #(
  parameter int               ACK_TIMEOUT = 8,
  parameter logic [CMD_W-1:0] CMD_WR_UPD  = CMD_WR_UPD_DEF
) (
  input  logic      i_FPGA_clk,
  input  logic      i_FPGA_rst,
  dac_sched_if.slave bus
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t            state;
  logic [PTR_W-1:0]  pointer;
  logic [CNT_W-1:0]  ack_cnt;
  logic [NREQ-1:0]   grant;
  logic [WORD_W-1:0] dac_data;
  logic              data_valid;
  logic              busy;

  logic [NREQ-1:0]   rr_grant;
  logic              rr_valid;
  logic [PTR_W-1:0]  win_idx;
  logic [CHAN_W-1:0] win_chan;
  logic [CODE_W-1:0] win_code;

  dac_rr_arbiter u_arb (
    .req     (bus.i_req),
    .pointer (pointer),
    .grant   (rr_grant),
    .valid   (rr_valid)
  );

  always_comb begin
    win_idx  = onehot_to_idx(rr_grant);
    win_chan = bus.i_chan[win_idx*CHAN_W +: CHAN_W];
    win_code = bus.i_code[win_idx*CODE_W +: CODE_W];
  end

`ifdef DAC_SCHED_BROADCAST_EN
  logic bcast_ack;
`endif

  always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
    if (!i_FPGA_rst) begin
      state      <= ST_IDLE;
      pointer    <= '0;
      ack_cnt    <= '0;
      grant      <= '0;
      dac_data   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef DAC_SCHED_BROADCAST_EN
      bcast_ack  <= 1'b0;
`endif
    end else begin
      grant      <= '0;
      data_valid <= 1'b0;
`ifdef DAC_SCHED_BROADCAST_EN
      bcast_ack  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (bus.i_drv_ready) begin
`ifdef DAC_SCHED_BROADCAST_EN
            // Broadcast pre-empts the ring and leaves the pointer alone
            if (bus.i_bcast_req) begin
              dac_data   <= pack_word(CMD_BCAST, '0, bus.i_bcast_code);
              bcast_ack  <= 1'b1;
              data_valid <= 1'b1;
              busy       <= 1'b1;
              state      <= ST_ISSUE;
            end else
`endif
            if (rr_valid) begin
              dac_data   <= pack_word(CMD_WR_UPD, win_chan, win_code);
              grant      <= rr_grant;
              pointer    <= win_idx + PTR_W'(1);
              data_valid <= 1'b1;
              busy       <= 1'b1;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          ack_cnt <= '0;
          state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!bus.i_drv_ready) begin
            state <= ST_WAIT_DONE;
          end else if (ack_cnt == CNT_LAST) begin
            // Driver never took the word: re-strobe the same latched word
            ack_cnt    <= '0;
            data_valid <= 1'b1;
            state      <= ST_ISSUE;
          end else begin
            ack_cnt <= ack_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (bus.i_drv_ready) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_grant     = grant;
  assign bus.o_DAC_DATA  = dac_data;
  assign bus.o_DataValid = data_valid;
  assign bus.o_busy      = busy;
`ifdef DAC_SCHED_BROADCAST_EN
  assign bus.o_bcast_ack = bcast_ack;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dac_channel_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_dac_channel_scheduler: directed scoreboard bench for the scheduler.|
// |                                                 Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dac_channel_scheduler;

  localparam int ACK_TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_sched_if bus ();

  dac_channel_scheduler #(.ACK_TIMEOUT(ACK_TO), .CMD_WR_UPD(4'h3)) dut (
    .i_FPGA_clk (clk),
    .i_FPGA_rst (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [3:0]  grant;
    logic        bcast;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [3:0] ch, input logic [15:0] cd);
    return {4'h3, ch, cd, 8'h00};
  endfunction

  task automatic set_req(input int k, input logic [3:0] ch, input logic [15:0] cd);
    bus.i_chan[4*k +: 4]   = ch;
    bus.i_code[16*k +: 16] = cd;
    bus.i_req[k]           = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_grant"}, 32'(bus.o_grant), 0);
    chk({tag, "_dv"},    32'(bus.o_DataValid), 0);
    chk({tag, "_data"},  bus.o_DAC_DATA, 0);
    chk({tag, "_busy"},  32'(bus.o_busy), 0);
  endtask

  // Waits (bounded) for a grant/ack pulse, then checks it against the scoreboard head
  task automatic wait_grant(input string tag);
    int   n;
    logic seen;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      if (bus.o_grant != 4'b0000) seen = 1'b1;
`ifdef DAC_SCHED_BROADCAST_EN
      if (bus.o_bcast_ack) seen = 1'b1;
`endif
      if (!seen) begin
        tick();
        n++;
      end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_grant"}, 32'(bus.o_grant), 32'(e.grant));
`ifdef DAC_SCHED_BROADCAST_EN
    chk({tag, "_bcast_ack"}, 32'(bus.o_bcast_ack), 32'(e.bcast));
`endif
    chk({tag, "_word"}, bus.o_DAC_DATA, e.word);
    chk({tag, "_dv"},   32'(bus.o_DataValid), 1);
  endtask

  // Driver model for one frame: accept the word, hold ready low, release
  task automatic serve_frame(input string tag);
    bus.i_drv_ready = 1'b0;
    tick();
    chk({tag, "_dv_single"}, 32'(bus.o_DataValid), 0);
    tick();
    chk({tag, "_busy_done"}, 32'(bus.o_busy), 1);
    bus.i_drv_ready = 1'b1;
    tick();
    chk({tag, "_busy_idle"}, 32'(bus.o_busy), 0);
    chk({tag, "_grant_idle"}, 32'(bus.o_grant), 0);
  endtask

  initial begin
    int   n;
    int   dv_cnt;
    bus.i_req       = '0;
    bus.i_chan      = '0;
    bus.i_code      = '0;
    bus.i_drv_ready = 1'b1;
`ifdef DAC_SCHED_BROADCAST_EN
    bus.i_bcast_req  = 1'b0;
    bus.i_bcast_code = '0;
`endif

    // Reset state
    tick();
    tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Round robin with all four requesting
    for (int k = 0; k < 4; k++) set_req(k, 4'(k + 1), 16'hA000 + 16'(k));
    for (int k = 0; k < 5; k++)
      sb.push_back('{4'(1 << (k % 4)), 1'b0, mk(4'((k % 4) + 1), 16'hA000 + 16'(k % 4))});
    for (int j = 0; j < 5; j++) begin
      wait_grant("rr");
      if (j == 4) bus.i_req = '0;
      serve_frame("rr");
    end

    // Single requester 2, chan 5, code 1234
    bus.i_chan[11:8]  = 4'h5;
    bus.i_code[47:32] = 16'h1234;
    bus.i_req         = 4'b0100;
    sb.push_back('{4'b0100, 1'b0, 32'h35123400});
    wait_grant("single");
    bus.i_req = '0;
    serve_frame("single");
    dv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.o_DataValid || bus.o_grant != 4'b0000) dv_cnt++;
      tick();
    end
    chk("single_no_extra", 32'(dv_cnt), 0);

    // Driver never acknowledges: periodic reissue of the same word
    set_req(3, 4'h9, 16'hBEEF);
    sb.push_back('{4'b1000, 1'b0, mk(4'h9, 16'hBEEF)});
    wait_grant("reissue");
    bus.i_req          = '0;
    bus.i_code[63:48]  = 16'h0000;
    bus.i_chan[15:12]  = 4'h1;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!bus.o_DataValid && n < 30);
      chk("reissue_gap",   32'(n), 32'(ACK_TO + 1));
      chk("reissue_word",  bus.o_DAC_DATA, mk(4'h9, 16'hBEEF));
      chk("reissue_grant", 32'(bus.o_grant), 0);
    end

    // Requester 0 drops before it can be granted; requester 1 must win
    set_req(0, 4'hC, 16'h0C0C);
    set_req(1, 4'hD, 16'h0D0D);
    bus.i_drv_ready = 1'b0;
    tick();
    tick();
    bus.i_req[0]    = 1'b0;
    bus.i_drv_ready = 1'b1;
    sb.push_back('{4'b0010, 1'b0, mk(4'hD, 16'h0D0D)});
    wait_grant("skip");
    bus.i_req = '0;
    serve_frame("skip");

    // Reset in the middle of a frame
    set_req(2, 4'h7, 16'h5555);
    sb.push_back('{4'b0100, 1'b0, mk(4'h7, 16'h5555)});
    wait_grant("midrst");
    bus.i_req       = '0;
    bus.i_drv_ready = 1'b0;
    tick();
    tick();
    chk("midrst_in_done", 32'(bus.o_busy), 1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("rst_now");
    tick();
    check_outputs_zero("rst_next");
    rst_n = 1'b1;
    set_req(0, 4'h2, 16'h2222);
    set_req(3, 4'h8, 16'h8888);
    for (int i = 0; i < 3; i++) tick();
    chk("postrst_needs_ready", 32'(bus.o_grant), 0);
    chk("postrst_idle", 32'(bus.o_busy), 0);
    bus.i_drv_ready = 1'b1;
    sb.push_back('{4'b0001, 1'b0, mk(4'h2, 16'h2222)});
    wait_grant("postrst");
    bus.i_req = '0;
    serve_frame("postrst");

`ifdef DAC_SCHED_BROADCAST_EN
    // Broadcast beats a pending requester, then requester 1 is served
    bus.i_bcast_req  = 1'b1;
    bus.i_bcast_code = 16'hFFFF;
    set_req(1, 4'h6, 16'h4242);
    sb.push_back('{4'b0000, 1'b1, 32'hA0FFFF00});
    sb.push_back('{4'b0010, 1'b0, mk(4'h6, 16'h4242)});
    wait_grant("bcast");
    bus.i_bcast_req = 1'b0;
    serve_frame("bcast");
    wait_grant("bcast_req1");
    bus.i_req = '0;
    serve_frame("bcast_req1");
`endif

    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
